// File: rtl/acia_rx_fifo.sv
// acia_rx_fifo: receive-side FIFO for an ACIA-style UART.
// Buffers bytes from the serial receiver together with their framing/format
// error flag until the bus side reads them, with first-word fall-through output.
//
// Ports:
//   clk      in   system clock, all state updates on the rising edge
//   reset_n  in   synchronous active-low reset
//   rx_dat   in   [7:0] received byte
//   rx_stb   in   one-cycle strobe, rx_dat/rx_err valid
//   rx_err   in   error flag accompanying rx_dat
//   rd       in   one-cycle pop request
//   ovr_clr  in   clears the sticky overrun flag
//   dout     out  [7:0] byte at FIFO head
//   derr     out  error flag stored with the head byte
//   empty    out  count == 0
//   full     out  count == DEPTH
//   hiwat    out  count >= THRESH
//   overrun  out  sticky: a strobed byte was dropped
//   count    out  [$clog2(DEPTH):0] number of stored entries
module acia_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int THRESH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [7:0]               rx_dat,
  input  logic                     rx_stb,
  input  logic                     rx_err,
  input  logic                     rd,
  input  logic                     ovr_clr,
  output logic [7:0]               dout,
  output logic                     derr,
  output logic                     empty,
  output logic                     full,
  output logic                     hiwat,
  output logic                     overrun,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [8:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_overrun;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_drop;

  always_comb begin
    w_empty = (r_count == '0);
    w_full  = (r_count == CW'(DEPTH));
    // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
    w_push  = rx_stb && (!w_full || rd);
    // On an empty FIFO a simultaneous push wins and the pop is ignored.
    w_pop   = rd && !w_empty;
    w_drop  = rx_stb && w_full && !rd;
  end

  // Pointers are AW bits wide and DEPTH is a power of two, so the natural
  // binary rollover gives the modulo-DEPTH wrap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      // A new drop in the same cycle as the clear keeps the flag set.
      if (w_drop)       r_overrun <= 1'b1;
      else if (ovr_clr) r_overrun <= 1'b0;
    end
  end

  // Storage is not reset; contents are only observed while non-empty.
  always_ff @(posedge clk) begin
    if (reset_n && w_push) r_mem[r_wptr] <= {rx_err, rx_dat};
  end

  always_comb begin
    dout    = r_mem[r_rptr][7:0];
    derr    = r_mem[r_rptr][8];
    empty   = w_empty;
    full    = w_full;
    hiwat   = (r_count >= CW'(THRESH));
    overrun = r_overrun;
    count   = r_count;
  end

endmodule

// File: doc/acia_rx_fifo.md
ACIA_RX_FIFO -- requirements
Module: acia_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of stored entries (power of two, >= 4).
REQ-002 SHALL have parameter THRESH, default 8, fill level at which hiwat asserts (1..DEPTH).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port rx_dat  input  8  received byte from the serial receiver.
REQ-006 SHALL have port rx_stb  input  1  one-cycle strobe; rx_dat/rx_err valid this cycle.
REQ-007 SHALL have port rx_err  input  1  framing/format error flag accompanying rx_dat.
REQ-008 SHALL have port rd  input  1  one-cycle pop request from the bus-side data-register read.
REQ-009 SHALL have port ovr_clr  input  1  clears the sticky overrun flag.
REQ-010 SHALL have port dout  output  8  byte at FIFO head (first-word fall-through).
REQ-011 SHALL have port derr  output  1  error flag stored with the head byte.
REQ-012 SHALL have port empty  output  1  high when count == 0.
REQ-013 SHALL have port full  output  1  high when count == DEPTH.
REQ-014 SHALL have port hiwat  output  1  high when count >= THRESH.
REQ-015 SHALL have port overrun  output  1  sticky: a strobed byte was dropped.
REQ-016 SHALL have port count  output  $clog2(DEPTH)+1  current number of stored entries.

Function
REQ-017 SHALL store 9-bit entries {rx_err, rx_dat} in a DEPTH-entry circular buffer with write pointer, read pointer and occupancy counter.
REQ-018 SHALL push on any cycle with rx_stb high and (count < DEPTH, or rd high with count == DEPTH).
REQ-019 SHALL pop on any cycle with rd high and count > 0; rd with count == 0 ignored, no state change.
REQ-020 SHALL update count per cycle: push only +1; pop only -1; push and pop together unchanged.
REQ-021 SHALL, with rx_stb high, count == DEPTH and rd low, discard the byte, leave pointers/count unchanged, set overrun.
REQ-022 SHALL wrap both pointers from DEPTH-1 to 0 modulo DEPTH; no other pointer arithmetic.
REQ-023 SHALL drive dout/derr combinationally from the entry at the read pointer; content is don't-care when empty.
REQ-024 SHALL make a byte pushed at edge N visible on dout, with empty low, in the cycle following edge N (one-cycle latency).
REQ-025 SHALL, with count == 0 and rx_stb and rd high together, accept the push, ignore the pop; count becomes 1.
REQ-026 SHALL derive empty, full and hiwat combinationally from count only.
REQ-027 SHALL clear overrun at the edge where ovr_clr is high; a simultaneous new overrun wins (overrun stays 1).
REQ-028 SHALL not alter stored entries on pop; only the read pointer moves.

Reset
REQ-029 SHALL, at a clk edge with reset_n low, zero both pointers and count, and clear overrun; empty=1, full=0, hiwat=0, count=0.
REQ-030 SHALL not require buffer memory to be cleared by reset; dout/derr undefined while empty.
REQ-031 SHALL ignore rx_stb, rd and ovr_clr in any cycle reset_n is low; reset mid-operation discards all stored bytes.

Verification
REQ-032 SHALL pass: reset, strobe 0x41 (err=0) -> next cycle empty=0, count=1, dout=0x41, derr=0; pulse rd -> empty=1, count=0.
REQ-033 SHALL pass: strobe 0x00..0x0F (DEPTH=16) -> full=1, hiwat=1 from count 8; 16 pops return 0x00..0x0F in order, empty after last.
REQ-034 SHALL pass: full FIFO, strobe 0x55 -> overrun=1, count=16, head unchanged; ovr_clr pulse -> overrun=0.
REQ-035 SHALL pass: full FIFO, rx_stb(0x99) and rd same cycle -> count stays 16, overrun=0, 0x99 popped last after wrap.
REQ-036 SHALL pass: empty FIFO, rx_stb(0x7E, err=1) with rd -> count=1, dout=0x7E, derr=1.
REQ-037 SHALL pass: 5 entries stored, overrun=1, reset_n low one cycle -> count=0, empty=1, overrun=0; subsequent push/pop correct.
